// File: rtl/codificador_hamming.sv
// Hamming(7,4) encoder feeding a codeword FIFO with valid/ready on both sides.
// Optional macro CODIFICADOR_INJETA_ERRO_EN adds Erro_pos to flip one stored codeword bit.
module codificador_hamming #(
  parameter int  PROFUNDIDADE = 4,
  localparam int LARG_PONT    = $clog2(PROFUNDIDADE)
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 Controle,
`ifdef CODIFICADOR_INJETA_ERRO_EN
  input  logic [2:0]           Erro_pos,
`endif
  input  logic [3:0]           Entrada,
  input  logic                 Entrada_valida,
  output logic                 Entrada_pronta,
  output logic [6:0]           Saida,
  output logic                 Saida_valida,
  input  logic                 Saida_pronta,
  output logic [LARG_PONT:0]   Ocupacao
);

  localparam logic [LARG_PONT:0] CHEIO = (LARG_PONT + 1)'(PROFUNDIDADE);

  logic [6:0]           mem_q [PROFUNDIDADE];
  logic [LARG_PONT-1:0] wr_ptr_q, wr_ptr_d;
  logic [LARG_PONT-1:0] rd_ptr_q, rd_ptr_d;
  logic [LARG_PONT:0]   ocup_q, ocup_d;
  logic                 ativo_q;
  logic [6:0]           palavra_limpa;
  logic [6:0]           palavra_gravada;
  logic                 push;
  logic                 pop;

  always_comb begin
    palavra_limpa[6:3] = Entrada;
    palavra_limpa[0]   = Entrada[0] ^ Entrada[1] ^ Entrada[3];
    palavra_limpa[1]   = Entrada[0] ^ Entrada[2] ^ Entrada[3];
    palavra_limpa[2]   = Entrada[1] ^ Entrada[2] ^ Entrada[3];
  end

`ifdef CODIFICADOR_INJETA_ERRO_EN
  logic [6:0] mascara_erro;
  // Erro_pos counts codeword bits from 1; zero means no corruption.
  assign mascara_erro    = (Erro_pos == 3'd0) ? 7'd0 : 7'(7'd1 << (Erro_pos - 3'd1));
  assign palavra_gravada = palavra_limpa ^ mascara_erro;
`else
  assign palavra_gravada = palavra_limpa;
`endif

  // ativo_q keeps the input side closed while reset is asserted.
  assign Entrada_pronta = ativo_q & Controle & (ocup_q != CHEIO);
  assign Saida_valida   = Controle & (ocup_q != '0);
  assign Saida          = Saida_valida ? mem_q[rd_ptr_q] : 7'd0;
  assign Ocupacao       = ocup_q;

  assign push = Entrada_valida & Entrada_pronta;
  assign pop  = Saida_valida & Saida_pronta;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ocup_d   = ocup_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + LARG_PONT'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + LARG_PONT'(1);
    end
    if (push && !pop) begin
      ocup_d = ocup_q + (LARG_PONT + 1)'(1);
    end else if (pop && !push) begin
      ocup_d = ocup_q - (LARG_PONT + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ocup_q   <= '0;
      ativo_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ocup_q   <= ocup_d;
      ativo_q  <= 1'b1;
    end
  end

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= palavra_gravada;
    end
  end

endmodule

// File: tb/tb_codificador_hamming.sv
// Scoreboard bench for codificador_hamming: expected codewords are queued on push
// and compared at the FIFO head every cycle.
module tb_codificador_hamming;

  localparam int PROF = 4;

  logic       clk = 1'b0;
  logic       Reset;
  logic       Controle;
  logic [2:0] Erro_pos;
  logic [3:0] Entrada;
  logic       Entrada_valida;
  logic       Entrada_pronta;
  logic [6:0] Saida;
  logic       Saida_valida;
  logic       Saida_pronta;
  logic [2:0] Ocupacao;

  int         n_vec = 0;
  int         n_err = 0;
  logic [6:0] fila[$];
  bit         ativo_m = 1'b0;

  always #5 clk = ~clk;

  codificador_hamming #(.PROFUNDIDADE(PROF)) dut (
    .clk            (clk),
    .Reset          (Reset),
    .Controle       (Controle),
`ifdef CODIFICADOR_INJETA_ERRO_EN
    .Erro_pos       (Erro_pos),
`endif
    .Entrada        (Entrada),
    .Entrada_valida (Entrada_valida),
    .Entrada_pronta (Entrada_pronta),
    .Saida          (Saida),
    .Saida_valida   (Saida_valida),
    .Saida_pronta   (Saida_pronta),
    .Ocupacao       (Ocupacao)
  );

  task automatic verifica(input string tag, input logic [7:0] obs, input logic [7:0] esp);
    n_vec++;
    if (obs !== esp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
    end
  endtask

  function automatic logic [6:0] codifica(input logic [3:0] d, input logic [2:0] ep);
    logic [6:0] c;
    c = {d, d[1] ^ d[2] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
`ifdef CODIFICADOR_INJETA_ERRO_EN
    if (ep != 3'd0) c[ep - 3'd1] = ~c[ep - 3'd1];
`else
    if (ep != 3'd0) c = c;
`endif
    return c;
  endfunction

  // Called just after a falling edge: drive, check registered outputs, advance the model.
  task automatic ciclo(input bit ev, input logic [3:0] d, input bit sr, input bit ctl,
                       input logic [2:0] ep);
    bit exp_v, exp_r;
    Entrada_valida = ev;
    Entrada        = d;
    Saida_pronta   = sr;
    Controle       = ctl;
    Erro_pos       = ep;
    #1;
    exp_v = ctl && (fila.size() != 0);
    exp_r = ctl && ativo_m && (fila.size() != PROF);
    verifica("pronta", {7'd0, Entrada_pronta}, {7'd0, exp_r});
    verifica("valida", {7'd0, Saida_valida}, {7'd0, exp_v});
    verifica("saida", {1'b0, Saida}, exp_v ? {1'b0, fila[0]} : 8'd0);
    verifica("ocup", {5'd0, Ocupacao}, 8'(fila.size()));
    @(posedge clk);
    if (exp_v && sr) begin
      $display("pop  %b (ocup %0d)", fila[0], fila.size() - 1);
      void'(fila.pop_front());
    end
    if (ev && exp_r) begin
      fila.push_back(codifica(d, ep));
      $display("push %b -> %b", d, codifica(d, ep));
    end
    ativo_m = 1'b1;
    @(negedge clk);
  endtask

  task automatic reset_assincrono();
    #2 Reset = 1'b0;
    #1;
    fila.delete();
    ativo_m = 1'b0;
    verifica("rst_ocup", {5'd0, Ocupacao}, 8'd0);
    verifica("rst_valida", {7'd0, Saida_valida}, 8'd0);
    verifica("rst_saida", {1'b0, Saida}, 8'd0);
    verifica("rst_pronta", {7'd0, Entrada_pronta}, 8'd0);
    @(negedge clk);
    Reset = 1'b1;
  endtask

  initial begin
    logic [3:0] lista[4];
    lista = '{4'b0000, 4'b1111, 4'b0001, 4'b0110};
    Reset = 1'b0; Controle = 1'b1; Erro_pos = 3'd0; Entrada = 4'd0;
    Entrada_valida = 1'b0; Saida_pronta = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    verifica("init_ocup", {5'd0, Ocupacao}, 8'd0);
    verifica("init_valida", {7'd0, Saida_valida}, 8'd0);
    verifica("init_saida", {1'b0, Saida}, 8'd0);
    verifica("init_pronta", {7'd0, Entrada_pronta}, 8'd0);
    Reset = 1'b1;
    ciclo(0, 4'd0, 0, 1, 3'd0);
    ciclo(0, 4'd0, 0, 1, 3'd0);

    // First codeword, checked against a fixed value as well as the model.
    ciclo(1, 4'b1011, 0, 1, 3'd0);
    #1;
    verifica("cw1011", {1'b0, Saida}, 8'b0101_1001);
    verifica("cw1011_ocup", {5'd0, Ocupacao}, 8'd1);
    ciclo(0, 4'd0, 1, 1, 3'd0);

    foreach (lista[i]) ciclo(1, lista[i], 0, 1, 3'd0);
    #1;
    verifica("cheio_pronta", {7'd0, Entrada_pronta}, 8'd0);
    verifica("cheio_ocup", {5'd0, Ocupacao}, 8'd4);
    verifica("cabeca_0000", {1'b0, Saida}, 8'd0);
    repeat (5) ciclo(0, 4'd0, 1, 1, 3'd0);

    // Full FIFO with both sides streaming, then drain; pointers wrap several times.
    repeat (4) ciclo(1, 4'($urandom), 0, 1, 3'd0);
    repeat (10) ciclo(1, 4'($urandom), 1, 1, 3'd0);
    repeat (6) ciclo(0, 4'd0, 1, 1, 3'd0);

    // Controle low freezes both handshakes and the stored words.
    ciclo(1, 4'b0101, 0, 1, 3'd0);
    ciclo(1, 4'b1100, 0, 1, 3'd0);
    repeat (5) ciclo(1, 4'($urandom), 1, 0, 3'd0);
    #1;
    verifica("congelado_ocup", {5'd0, Ocupacao}, 8'd2);
    repeat (3) ciclo(0, 4'd0, 1, 1, 3'd0);

    repeat (200) ciclo(1'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0), 3'd0);
    repeat (6) ciclo(0, 4'd0, 1, 1, 3'd0);

`ifdef CODIFICADOR_INJETA_ERRO_EN
    ciclo(1, 4'b1011, 0, 1, 3'd7);
    #1;
    verifica("erro7", {1'b0, Saida}, 8'b0001_1001);
    ciclo(1, 4'b1011, 1, 1, 3'd0);
    #1;
    verifica("erro0", {1'b0, Saida}, 8'b0101_1001);
    repeat (30) ciclo(1'($urandom), 4'($urandom), 1'($urandom), 1, 3'($urandom));
    repeat (6) ciclo(0, 4'd0, 1, 1, 3'd0);
`endif

    // Asynchronous reset with three words stored discards them immediately.
    repeat (3) ciclo(1, 4'($urandom), 0, 1, 3'd0);
    reset_assincrono();
    ciclo(1, 4'b0110, 0, 1, 3'd0);
    ciclo(1, 4'b0110, 0, 1, 3'd0);
    repeat (3) ciclo(0, 4'd0, 1, 1, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
